// File: rtl/fifo_param_if.sv
// rtl/fifo_param_if.sv - handshake bundle between a fifo_param and its user
interface fifo_param_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_in;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic [CW-1:0]    count;

  // user side: drives requests, observes data and status
  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, full, empty, almostfull, almostempty,
    input  wr_ack, overflow, underflow, count
  );

  // fifo side
  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, full, empty, almostfull, almostempty,
    output wr_ack, overflow, underflow, count
  );
endinterface

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - single-clock parameterised fifo, registered or fall-through read
module fifo_param #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  fifo_param_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full_c;
  logic             empty_c;
  logic             do_wr;
  logic             do_rd;

  // pointers wrap explicitly so DEPTH need not be a power of two
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  // a full fifo still reads and an empty one still writes, so gating each side
  // only by its own flag gives the read-only / write-only collision behaviour
  assign do_wr   = bus.wr_en && !full_c;
  assign do_rd   = bus.rd_en && !empty_c;

  assign bus.count       = count;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (count >= CW'(AF_LEVEL)) && !full_c;
  assign bus.almostempty = (count <= CW'(AE_LEVEL)) && !empty_c;

  // pointer, occupancy and one-cycle status tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.wr_ack    <= do_wr;
      bus.overflow  <= bus.wr_en && full_c;
      bus.underflow <= bus.rd_en && empty_c;
    end
  end

  // storage carries no reset; occupancy alone says which entries are valid
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // head entry is visible as soon as the fifo holds anything
      assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      // registered read: capture the head on a performed read, hold otherwise
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     data_q <= '0;
        else if (do_rd) data_q <= mem[rd_ptr];
      end
      assign bus.data_out = data_q;
    end
  endgenerate
endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - self-checking bench for fifo_param in registered and fall-through modes
module tb_fifo_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_param_if #(.WIDTH(16), .DEPTH(8)) if_a ();
  fifo_param_if #(.WIDTH(16), .DEPTH(5)) if_b ();

  fifo_param #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  fifo_param #(.WIDTH(16), .DEPTH(5), .FWFT(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;

  // reference model: plain queues, A keeps its last popped word as read data
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [15:0] da = '0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    int          cnt;
    logic [15:0] dout;
    logic [6:0]  flg;   // full, empty, almostfull, almostempty, wr_ack, overflow, underflow
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_flags(input int n, input int d, input int af, input int ae,
                                           input logic ack, input logic ov, input logic un);
    return {n == d, n == 0, (n >= af) && (n != d), (n <= ae) && (n != 0), ack, ov, un};
  endfunction

  function automatic logic [6:0] flags_a();
    return {if_a.full, if_a.empty, if_a.almostfull, if_a.almostempty,
            if_a.wr_ack, if_a.overflow, if_a.underflow};
  endfunction

  function automatic logic [6:0] flags_b();
    return {if_b.full, if_b.empty, if_b.almostfull, if_b.almostempty,
            if_b.wr_ack, if_b.overflow, if_b.underflow};
  endfunction

  // one clock of identical stimulus to both fifos, checked against the model
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] din);
    int sa, sb;
    logic ack_a, ov_a, un_a, ack_b, ov_b, un_b;
    logic [15:0] junk;
    if_a.wr_en = wr; if_a.rd_en = rd; if_a.data_in = din;
    if_b.wr_en = wr; if_b.rd_en = rd; if_b.data_in = din;
    sa = qa.size(); sb = qb.size();
    ack_a = wr && (sa < 8); ov_a = wr && (sa == 8); un_a = rd && (sa == 0);
    ack_b = wr && (sb < 5); ov_b = wr && (sb == 5); un_b = rd && (sb == 0);
    if (rd && sa > 0) da = qa.pop_front();
    if (ack_a) qa.push_back(din);
    if (rd && sb > 0) junk = qb.pop_front();
    if (ack_b) qb.push_back(din);
    @(posedge clk); #1;
    chk("a_count", if_a.count, qa.size());
    chk("a_dout", if_a.data_out, da);
    chk("a_flags", flags_a(), exp_flags(qa.size(), 8, 6, 2, ack_a, ov_a, un_a));
    chk("b_count", if_b.count, qb.size());
    chk("b_dout", if_b.data_out, (qb.size() > 0) ? qb[0] : 16'h0);
    chk("b_flags", flags_b(), exp_flags(qb.size(), 5, 4, 1, ack_b, ov_b, un_b));
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    if_a.wr_en = 0; if_a.rd_en = 0; if_b.wr_en = 0; if_b.rd_en = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_a_count", if_a.count, 0);
    chk("rst_a_dout", if_a.data_out, 0);
    chk("rst_a_flags", flags_a(), 7'b0100000);
    chk("rst_b_dout", if_b.data_out, 0);
    chk("rst_b_flags", flags_b(), 7'b0100000);
    qa.delete(); qb.delete(); da = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h0000, 0, 16'h0000, 7'b0100001};
    tbl[1]  = '{1'b1, 1'b0, 16'h0001, 1, 16'h0000, 7'b0001100};
    tbl[2]  = '{1'b1, 1'b0, 16'h0002, 2, 16'h0000, 7'b0001100};
    tbl[3]  = '{1'b1, 1'b0, 16'h0003, 3, 16'h0000, 7'b0000100};
    tbl[4]  = '{1'b1, 1'b1, 16'h0004, 3, 16'h0001, 7'b0000100};
    tbl[5]  = '{1'b1, 1'b0, 16'h0005, 4, 16'h0001, 7'b0000100};
    tbl[6]  = '{1'b1, 1'b0, 16'h0006, 5, 16'h0001, 7'b0000100};
    tbl[7]  = '{1'b1, 1'b0, 16'h0007, 6, 16'h0001, 7'b0010100};
    tbl[8]  = '{1'b1, 1'b0, 16'h0008, 7, 16'h0001, 7'b0010100};
    tbl[9]  = '{1'b1, 1'b0, 16'h0009, 8, 16'h0001, 7'b1000100};
    tbl[10] = '{1'b1, 1'b0, 16'h000A, 8, 16'h0001, 7'b1000010};
    tbl[11] = '{1'b1, 1'b1, 16'h000B, 7, 16'h0002, 7'b0010010};
    tbl[12] = '{1'b0, 1'b1, 16'h0000, 6, 16'h0003, 7'b0010000};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 6, 16'h0003, 7'b0010000};

    if_a.wr_en = 0; if_a.rd_en = 0; if_a.data_in = '0;
    if_b.wr_en = 0; if_b.rd_en = 0; if_b.data_in = '0;
    #12;
    chk("init_a_count", if_a.count, 0);
    chk("init_a_dout", if_a.data_out, 0);
    chk("init_a_flags", flags_a(), 7'b0100000);
    chk("init_b_flags", flags_b(), 7'b0100000);
    @(negedge clk);
    rst_n = 1'b1;

    // fixed vectors on the registered-read fifo
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("tbl%0d_count", i), if_a.count, tbl[i].cnt);
      chk($sformatf("tbl%0d_dout", i), if_a.data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_flags", i), flags_a(), tbl[i].flg);
    end

    // reset in the middle of a write burst, then the first read underflows
    pulse_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0100 + 16'(i));
    pulse_reset();
    cyc(1'b0, 1'b1, 16'h0);
    chk("post_rst_underflow", if_a.underflow, 1);

    // fill to full, one rejected write, drain in order across the wrap
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 16'(i));
    cyc(1'b1, 1'b0, 16'h00FF);
    chk("fill_full", if_a.full, 1);
    chk("fill_overflow", if_a.overflow, 1);
    chk("fill_count", if_a.count, 8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 16'h0);
      chk($sformatf("drain%0d", i), if_a.data_out, 16'(i));
    end
    cyc(1'b0, 1'b1, 16'h0);
    chk("empty_read_hold", if_a.data_out, 16'h0008);

    // steady state at four entries with simultaneous read and write
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0200 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 16'h0300 + 16'(i));
      chk("steady_count", if_a.count, 4);
      chk("steady_ack", if_a.wr_ack, 1);
    end

    // fall-through: a single write becomes visible without a read
    pulse_reset();
    cyc(1'b1, 1'b0, 16'hABCD);
    chk("fwft_first_word", if_b.data_out, 16'hABCD);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 16'h0400 + 16'(i));

    // random traffic, write-heavy then read-heavy, against the model
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 The block SHALL expose parameter DEPTH, default 8, number of storage entries (2..1024, not restricted to powers of two).
REQ-003 The block SHALL expose parameter AF_LEVEL, default DEPTH-1, almost-full threshold in entries (1..DEPTH-1).
REQ-004 The block SHALL expose parameter AE_LEVEL, default 1, almost-empty threshold in entries (1..DEPTH-1, AE_LEVEL < AF_LEVEL).
REQ-005 The block SHALL expose parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 data_in  input  WIDTH  write data.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request (FWFT=1: pop acknowledge).
REQ-011 data_out  output  WIDTH  read data.
REQ-012 full, empty, almostfull, almostempty  output  1 each  occupancy flags.
REQ-013 wr_ack, overflow, underflow  output  1 each  registered write/error status.
REQ-014 count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 A write SHALL be accepted when wr_en=1 and full=0, storing data_in at wr_ptr; wr_ptr SHALL advance, wrapping DEPTH-1 -> 0.
REQ-016 A read SHALL be performed when rd_en=1 and empty=0; rd_ptr SHALL advance, wrapping DEPTH-1 -> 0.
REQ-017 Simultaneous wr_en and rd_en with 0 < count < DEPTH SHALL perform both; count unchanged.
REQ-018 Simultaneous wr_en and rd_en when empty SHALL perform the write only; underflow SHALL assert.
REQ-019 Simultaneous wr_en and rd_en when full SHALL perform the read only; overflow SHALL assert.
REQ-020 count SHALL increment on write-only, decrement on read-only, and never exceed DEPTH or go below 0.
REQ-021 full = (count == DEPTH); empty = (count == 0); both combinational from count.
REQ-022 almostfull = (count >= AF_LEVEL) and not full; almostempty = (count <= AE_LEVEL) and not empty.
REQ-023 wr_ack SHALL be 1 in the cycle after an accepted write, else 0.
REQ-024 overflow SHALL be 1 in the cycle after a rejected write (wr_en=1, full=1), else 0.
REQ-025 underflow SHALL be 1 in the cycle after a rejected read (rd_en=1, empty=1), else 0.
REQ-026 FWFT=0: data_out SHALL update on the clock edge of a performed read with the entry at rd_ptr (1-cycle latency) and SHALL hold otherwise.
REQ-027 FWFT=1: data_out SHALL present the entry at rd_ptr whenever empty=0 with zero read latency; a write into an empty FIFO SHALL appear on data_out the cycle after the write edge; rd_en pops that word.
REQ-028 A rejected write or read SHALL NOT modify pointers, count or storage.

Reset
REQ-029 rst_n low SHALL immediately, without clk, clear wr_ptr, rd_ptr, count, data_out, wr_ack, overflow and underflow to 0, giving empty=1, full=0, almostfull=0, almostempty=0.
REQ-030 Storage contents SHALL NOT need reset; data_out SHALL stay 0 while empty after reset in both modes.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; the first read after release SHALL underflow.
REQ-032 Reset release SHALL take effect on the first rising clk edge with rst_n high; no access occurs during reset.

Verification
REQ-033 Reset mid-burst: 3 writes, assert rst_n=0 between edges -> count=0, data_out=0, empty=1 before the next clk edge.
REQ-034 Fill DEPTH=8 with 0x0001..0x0008, one extra write -> full=1, overflow=1 one cycle later, count=8; drain reads 0x0001..0x0008 in order with pointer wrap.
REQ-035 Read when empty -> underflow=1 next cycle, count=0, data_out unchanged.
REQ-036 count=4, wr_en=rd_en=1 for 10 cycles -> count stays 4, wr_ack=1 each cycle, data order preserved.
REQ-037 Thresholds with AF_LEVEL=6, AE_LEVEL=2: count 6 -> almostfull=1; count 8 -> almostfull=0, full=1; count 2 -> almostempty=1; count 0 -> almostempty=0, empty=1.
REQ-038 FWFT=1, DEPTH=5: write 0xABCD to empty FIFO -> data_out=0xABCD the next cycle without rd_en; 7 writes/reads across wrap match order.
